// File: rtl/uart_rx_fifo.sv
// 16x-oversampling UART receiver (8N1, LSB first) feeding a small first-word
// fall-through FIFO, with framing-error pulse and sticky overflow flag.
module uart_rx_fifo #(
    parameter int CLKS_PER_TICK = 16,
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 empty,
    output logic                 full,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int N_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and oversample tick
    // ------------------------------------------------------------------
    logic              rx_meta_reg;
    logic              rx_sync_reg;
    logic [TICK_W-1:0] tick_cnt_reg;
    logic              tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    assign tick = (tick_cnt_reg == TICK_W'(CLKS_PER_TICK - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t               state_reg, state_next;
    logic [3:0]           s_reg, s_next;
    logic [N_W-1:0]       n_reg, n_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 byte_valid;
    logic                 stop_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        shift_next = shift_reg;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        if (tick) begin
            unique case (state_reg)
                IDLE: begin
                    if (!rx_sync_reg) begin
                        state_next = START;
                        s_next     = '0;
                    end
                end
                START: begin
                    // Re-check the line mid start bit so short glitches are dropped.
                    if (s_reg == 4'd7) begin
                        s_next = '0;
                        n_next = '0;
                        state_next = rx_sync_reg ? IDLE : DATA;
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
                DATA: begin
                    if (s_reg == 4'd15) begin
                        s_next                = '0;
                        shift_next            = shift_reg >> 1;
                        shift_next[DATA_BITS-1] = rx_sync_reg;
                        if (n_reg == N_W'(DATA_BITS - 1)) begin
                            n_next     = '0;
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
                STOP: begin
                    if (s_reg == 4'd15) begin
                        s_next = '0;
                        if (rx_sync_reg) begin
                            byte_valid = 1'b1;
                            state_next = IDLE;
                        end else begin
                            stop_err   = 1'b1;
                            state_next = WAIT_HIGH;
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low break stays here, so it reports only one error.
                    if (rx_sync_reg) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO (first-word fall-through, wrap-bit pointers)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [ADDR_W-1:0]    wr_addr;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 push_ok;
    logic                 pop;
    logic                 drop;
    logic                 rx_done_reg;
    logic                 frame_err_reg;
    logic                 overflow_reg;

    assign wr_addr = wr_ptr_reg[ADDR_W-1:0];
    assign rd_addr = rd_ptr_reg[ADDR_W-1:0];
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) && (wr_addr == rd_addr);

    // A simultaneous read frees the slot, so a push into a full FIFO still lands.
    assign push_ok = byte_valid && (!full || rd_en);
    assign drop    = byte_valid && full && !rd_en;
    assign pop     = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_addr] <= shift_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            rx_done_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            rx_done_reg   <= push_ok;
            frame_err_reg <= stop_err;
            overflow_reg  <= overflow_reg | drop;
        end
    end

    assign data_out  = empty ? '0 : mem[rd_addr];
    assign rx_done   = rx_done_reg;
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames at 256 clocks/bit, FIFO fill,
// overflow, simultaneous push/pop, framing errors, glitches and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPT = 16;
    localparam int BIT = 16 * CPT;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic [7:0] data_out;
    logic       rx_done;
    logic       empty;
    logic       full;
    logic       frame_err;
    logic       overflow;

    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] done_data = 8'h00;
    logic       done_empty = 1'b1;

    uart_rx_fifo #(
        .CLKS_PER_TICK(CPT),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rd_en    (rd_en),
        .data_out (data_out),
        .rx_done  (rx_done),
        .empty    (empty),
        .full     (full),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Pulse monitor: also snapshots FIFO outputs in the cycle rx_done is high.
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt   = done_cnt + 1;
            done_data  = data_out;
            done_empty = empty;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT);
        end
        rx = stop_bit;
        wait_clks(BIT);
        rx = 1'b1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        wait_clks(1);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", data_out); end
        n_cmp++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL reset_rx_done got=%b exp=0", rx_done); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_cmp++; if (dut.state_reg !== 3'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", dut.state_reg); end
        $display("reset: empty=%b full=%b data_out=%h overflow=%b", empty, full, data_out, overflow);
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        send_frame(8'hCE, 1'b1);
        wait_clks(BIT);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
        n_cmp++; if (done_data !== 8'hCE) begin n_err++; $display("FAIL basic_data_at_done got=%h exp=ce", done_data); end
        n_cmp++; if (done_empty !== 1'b0) begin n_err++; $display("FAIL basic_empty_at_done got=%b exp=0", done_empty); end
        n_cmp++; if (data_out !== 8'hCE) begin n_err++; $display("FAIL basic_data got=%h exp=ce", data_out); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL basic_empty got=%b exp=0", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL basic_full got=%b exp=0", full); end
        pop_one();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_empty_after_read got=%b exp=1", empty); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL basic_data_after_read got=%h exp=00", data_out); end
        $display("basic: sent ce, received %h, after read empty=%b", done_data, empty);
    endtask

    task automatic test_glitch();
        int d0;
        int f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_clks(3 * CPT);
        rx = 1'b1;
        wait_clks(2 * BIT);
        n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL glitch_done got=%0d exp=0", done_cnt - d0); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL glitch_frame_err got=%0d exp=0", ferr_cnt - f0); end
        n_cmp++; if (dut.state_reg !== 3'd0) begin n_err++; $display("FAIL glitch_state got=%0d exp=0", dut.state_reg); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL glitch_empty got=%b exp=1", empty); end
        $display("glitch: 3-tick low pulse, rx_done=%0d frame_err=%0d", done_cnt - d0, ferr_cnt - f0);
    endtask

    task automatic test_frame_err();
        int d0;
        int f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        wait_clks(40 * BIT);
        rx = 1'b1;
        wait_clks(2 * BIT);
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - f0); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL ferr_done got=%0d exp=0", done_cnt - d0); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ferr_empty got=%b exp=1", empty); end
        send_frame(8'hA3, 1'b1);
        wait_clks(BIT);
        n_cmp++; if (data_out !== 8'hA3) begin n_err++; $display("FAIL ferr_next_data got=%h exp=a3", data_out); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL ferr_next_done got=%0d exp=1", done_cnt - d0); end
        pop_one();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ferr_drain_empty got=%b exp=1", empty); end
        $display("frame_err: break gave %0d error pulse(s), then received %h", ferr_cnt - f0, done_data);
    endtask

    task automatic test_fill();
        int d0;
        d0 = done_cnt;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            wait_clks(BIT / 2);
            if (i == 3) begin
                n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_full_after_3 got=%b exp=0", full); end
            end
            if (i == 4) begin
                n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full_after_4 got=%b exp=1", full); end
                n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_overflow_after_4 got=%b exp=0", overflow); end
            end
            $display("fill: sent %02h full=%b overflow=%b", i, full, overflow);
        end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow_after_5 got=%b exp=1", overflow); end
        n_cmp++; if (done_cnt - d0 !== 4) begin n_err++; $display("FAIL fill_done_pulses got=%0d exp=4", done_cnt - d0); end
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (data_out !== 8'(i)) begin n_err++; $display("FAIL fill_read_%0d got=%h exp=%02h", i, data_out, i); end
            pop_one();
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_empty_after_reads got=%b exp=1", empty); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL fill_data_after_reads got=%h exp=00", data_out); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow_sticky got=%b exp=1", overflow); end
        $display("fill: drained, empty=%b overflow=%b", empty, overflow);
    endtask

    task automatic test_full_read_push();
        int d0;
        do_reset();
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL frp_overflow_cleared got=%b exp=0", overflow); end
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1);
            wait_clks(BIT / 2);
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL frp_full_before got=%b exp=1", full); end
        d0 = done_cnt;
        fork
            send_frame(8'h06, 1'b1);
            begin
                int k;
                k = 0;
                while (dut.byte_valid !== 1'b1 && k < 12 * BIT) begin
                    @(negedge clk);
                    k++;
                end
                n_cmp++;
                if (k >= 12 * BIT) begin
                    n_err++;
                    $display("FAIL frp_push_cycle_timeout waited=%0d limit=%0d", k, 12 * BIT);
                end else begin
                    rd_en = 1'b1;
                    @(negedge clk);
                    rd_en = 1'b0;
                end
            end
        join
        wait_clks(BIT / 2);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL frp_overflow got=%b exp=0", overflow); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL frp_full_after got=%b exp=1", full); end
        n_cmp++; if (data_out !== 8'h02) begin n_err++; $display("FAIL frp_head got=%h exp=02", data_out); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL frp_done got=%0d exp=1", done_cnt - d0); end
        pop_one();
        n_cmp++; if (data_out !== 8'h03) begin n_err++; $display("FAIL frp_head_2 got=%h exp=03", data_out); end
        pop_one();
        n_cmp++; if (data_out !== 8'h04) begin n_err++; $display("FAIL frp_head_3 got=%h exp=04", data_out); end
        $display("full_read_push: 06 pushed with read, head=%h full=%b overflow=%b", data_out, full, overflow);
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        logic [7:0] b;
        b = 8'h3C;
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL rmf_queued got=%b exp=0", empty); end
        d0 = done_cnt;
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_clks(BIT);
        end
        rx = b[4];
        wait_clks(BIT / 2);
        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2 * BIT);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rmf_empty got=%b exp=1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rmf_full got=%b exp=0", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rmf_overflow got=%b exp=0", overflow); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rmf_data got=%h exp=00", data_out); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL rmf_done got=%0d exp=0", done_cnt - d0); end
        send_frame(8'h7E, 1'b1);
        wait_clks(BIT);
        n_cmp++; if (data_out !== 8'h7E) begin n_err++; $display("FAIL rmf_next_data got=%h exp=7e", data_out); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL rmf_next_done got=%0d exp=1", done_cnt - d0); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL rmf_next_empty got=%b exp=0", empty); end
        $display("reset_mid_frame: after reset empty restored, then received %h", data_out);
    endtask

    initial begin
        rx    = 1'b1;
        rd_en = 1'b0;
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_fill();
        test_full_read_push();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001: The module SHALL have parameter CLKS_PER_TICK, default 16: clocks per oversample tick; one bit period = 16 ticks = 16*CLKS_PER_TICK clocks.
REQ-002: The module SHALL have parameter DATA_BITS, default 8: data bits per frame.
REQ-003: The module SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two, >=2.
REQ-004: The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005: The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006: The module SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007: The module SHALL have port rd_en, input, 1 bit: pop FIFO head this cycle.
REQ-008: The module SHALL have port data_out, output, DATA_BITS bits: FIFO head (first-word fall-through).
REQ-009: The module SHALL have port rx_done, output, 1 bit: one-cycle pulse, byte written to FIFO.
REQ-010: The module SHALL have port empty, output, 1 bit: FIFO empty.
REQ-011: The module SHALL have port full, output, 1 bit: FIFO full.
REQ-012: The module SHALL have port frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-013: The module SHALL have port overflow, output, 1 bit: sticky; byte dropped because FIFO full.

Function
REQ-014: rx SHALL pass through a two-flop synchronizer; both flops reset to 1; all decisions use the synchronized value.
REQ-015: A free-running tick counter SHALL count 0..CLKS_PER_TICK-1 and assert tick for one clock at CLKS_PER_TICK-1.
REQ-016: FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; tick-count s (0..15) and bit-count n are advanced only on tick.
REQ-017: IDLE: on a tick with synchronized rx=0 -> START, s=0.
REQ-018: START: at s=7 (mid start bit), rx=0 -> DATA, s=0, n=0; rx=1 -> IDLE, glitch rejected, no output activity.
REQ-019: DATA: at s=15, rx SHALL be shifted in LSB first and n incremented; after DATA_BITS samples -> STOP, s=0.
REQ-020: STOP at s=15 with rx=1: byte pushed to FIFO; rx_done pulses the following clock; -> IDLE.
REQ-021: STOP at s=15 with rx=0: byte discarded; frame_err pulses one clock; -> WAIT_HIGH.
REQ-022: WAIT_HIGH -> IDLE on the first tick with rx=1; a held-low (break) line SHALL produce exactly one frame_err.
REQ-023: FIFO push SHALL update empty, full and data_out in the same clock that rx_done is high.
REQ-024: data_out SHALL equal the oldest unread byte when empty=0, and 0 when empty=1.
REQ-025: rd_en with empty=1 SHALL be ignored; pointers unchanged.
REQ-026: Push with full=1 and rd_en=0: byte dropped, overflow set to 1, no rx_done.
REQ-027: Push and rd_en in the same cycle SHALL both take effect regardless of fill level, with no overflow; when empty, only the push takes effect.
REQ-028: Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer wrap bit.
REQ-029: overflow SHALL clear only on reset.

Reset
REQ-030: On reset: FSM=IDLE; s, n, tick counter, pointers=0; empty=1; full=0; data_out=0; rx_done=0; frame_err=0; overflow=0.
REQ-031: Reset asserted mid-frame SHALL discard the partial byte and all FIFO contents; reception resumes at the next falling edge after release.

Verification
REQ-032: Bench SHALL send 0xCE at 256 clocks/bit -> one rx_done pulse, data_out=0xCE, empty=0; rd_en for one clock -> empty=1, data_out=0.
REQ-033: Bench SHALL drive rx low for 3 ticks, then high -> no rx_done, no frame_err, FSM back to IDLE.
REQ-034: Bench SHALL send 0x55 with stop bit 0 and hold rx low 40 bit periods -> exactly one frame_err pulse, empty=1; then a valid 0xA3 -> data_out=0xA3.
REQ-035: Bench SHALL send 0x01..0x05 with no reads -> full=1 after 0x04, overflow=1 after 0x05, four rx_done pulses; four reads return 0x01,0x02,0x03,0x04, then empty=1.
REQ-036: With FIFO full, bench SHALL assert rd_en in the push cycle of 0x06 -> no overflow, full stays 1, head advances.
REQ-037: Bench SHALL assert reset at DATA bit 4 of 0x3C with two bytes queued -> empty=1, overflow=0, no rx_done; next frame 0x7E is received correctly.
